csr_trap_sequencer: RTL

- Multi-cycle controller that owns the single CSR write port and the trap-entry/return redirect in the pipelined RV32 core.
- Shares the port between EX-stage CSR-instruction writes and its own trap sequence (ecall, machine external interrupt, mret).
- Raises a stall/flush toward the hazard logic and issues the PC redirect.
- Sits beside the ID stage, between the ID/EX CSR write path and the CSR register file.

---
 rtl/csr_pkg.sv | 24 ++
 rtl/csr_trap_sequencer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared CSR addresses, bit indices, trap causes and sequencer states
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;

  localparam logic [31:0] CAUSE_ECALL_M   = 32'h0000_000B;
  localparam logic [31:0] CAUSE_IRQ_EXT_M = 32'h8000_000B;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    W_MEPC    = 3'd1,
    W_MCAUSE  = 3'd2,
    W_MSTATUS = 3'd3,
    R_MSTATUS = 3'd4,
    JUMP      = 3'd5
  } trap_state_e;

endpackage

// File: rtl/csr_trap_sequencer.sv
// rtl/csr_trap_sequencer.sv - CSR write-port owner and trap entry/return sequencer
module csr_trap_sequencer
  import csr_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_csr_we,
  input  logic [CSR_AW-1:0] ex_csr_wa,
  input  logic [XLEN-1:0]   ex_csr_wd,
  output logic              ex_csr_gnt,
  input  logic              id_ecall,
  input  logic              id_mret,
  input  logic              irq_ext,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   csr_mstatus,
  input  logic [XLEN-1:0]   csr_mtvec,
  input  logic [XLEN-1:0]   csr_mepc,
  output logic              csr_we,
  output logic [CSR_AW-1:0] csr_wa,
  output logic [XLEN-1:0]   csr_wd,
  output logic              stall_req,
  output logic              flush_req,
  output logic              jump_flag,
  output logic [XLEN-1:0]   jump_addr
);

  trap_state_e     state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] target_q, target_d;
  logic [XLEN-1:0] jump_hold_q, jump_hold_d;

  logic            irq_ok;
  logic            evt;
  logic [XLEN-1:0] mstatus_entry;
  logic [XLEN-1:0] mstatus_ret;

  // State and captured trap context; reset aborts any sequence in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      cause_q     <= '0;
      target_q    <= '0;
      jump_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cause_q     <= cause_d;
      target_q    <= target_d;
      jump_hold_q <= jump_hold_d;
    end
  end

  // Event selection, write-port mux and next-state logic
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cause_d     = cause_q;
    target_d    = target_q;
    jump_hold_d = jump_hold_q;

    ex_csr_gnt  = 1'b0;
    csr_we      = 1'b0;
    csr_wa      = '0;
    csr_wd      = '0;
    stall_req   = 1'b0;
    flush_req   = 1'b0;
    jump_flag   = 1'b0;
    jump_addr   = jump_hold_q;

    // Trap entry stacks MIE into MPIE and disables interrupts; mret undoes it
    mstatus_entry           = csr_mstatus;
    mstatus_entry[MPIE_BIT] = csr_mstatus[MIE_BIT];
    mstatus_entry[MIE_BIT]  = 1'b0;
    mstatus_ret             = csr_mstatus;
    mstatus_ret[MIE_BIT]    = csr_mstatus[MPIE_BIT];
    mstatus_ret[MPIE_BIT]   = 1'b1;

    irq_ok = irq_ext & csr_mstatus[MIE_BIT];
    evt    = id_ecall | id_mret | irq_ok;

    case (state_q)
      IDLE: begin
        csr_we     = ex_csr_we;
        csr_wa     = ex_csr_wa;
        csr_wd     = ex_csr_wd;
        ex_csr_gnt = ex_csr_we;
        // A pending EX write always wins the port; the event waits in ID
        stall_req  = evt;
        if (evt && !ex_csr_we) begin
          pc_d = id_pc;
          if (id_ecall) begin
            cause_d = XLEN'(CAUSE_ECALL_M);
            state_d = W_MEPC;
          end else if (id_mret) begin
            state_d = R_MSTATUS;
          end else begin
            cause_d = XLEN'(CAUSE_IRQ_EXT_M);
            state_d = W_MEPC;
          end
        end
      end
      W_MEPC: begin
        stall_req = 1'b1;
        csr_we    = 1'b1;
        csr_wa    = CSR_AW'(CSR_MEPC);
        csr_wd    = pc_q;
        state_d   = W_MCAUSE;
      end
      W_MCAUSE: begin
        stall_req = 1'b1;
        csr_we    = 1'b1;
        csr_wa    = CSR_AW'(CSR_MCAUSE);
        csr_wd    = cause_q;
        state_d   = W_MSTATUS;
      end
      W_MSTATUS: begin
        stall_req = 1'b1;
        csr_we    = 1'b1;
        csr_wa    = CSR_AW'(CSR_MSTATUS);
        csr_wd    = mstatus_entry;
        // Direct mode only: the mode field is simply masked off
        target_d  = csr_mtvec & ~XLEN'(3);
        state_d   = JUMP;
      end
      R_MSTATUS: begin
        stall_req = 1'b1;
        csr_we    = 1'b1;
        csr_wa    = CSR_AW'(CSR_MSTATUS);
        csr_wd    = mstatus_ret;
        target_d  = csr_mepc;
        state_d   = JUMP;
      end
      JUMP: begin
        stall_req   = 1'b1;
        flush_req   = 1'b1;
        jump_flag   = 1'b1;
        jump_addr   = target_q;
        jump_hold_d = target_q;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are forced quiet while reset is asserted, even the IDLE pass-through
    if (!rst) begin
      ex_csr_gnt = 1'b0;
      csr_we     = 1'b0;
      csr_wa     = '0;
      csr_wd     = '0;
      stall_req  = 1'b0;
      flush_req  = 1'b0;
      jump_flag  = 1'b0;
      jump_addr  = '0;
    end
  end

endmodule
